// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - next-PC select with stall, misaligned-target trap and optional return-address stack
// Define PC_RAS_EN to build the return-address stack; otherwise ras_push/ras_pop are ignored.
module pc_unit #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0,
  parameter logic [ADDRESS_WIDTH-1:0] TRAP_VECTOR   = 'h100,
  parameter int                       RAS_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               PCsrc,
  input  logic [ADDRESS_WIDTH-1:0] ImmOP,
  input  logic [ADDRESS_WIDTH-1:0] RegBase,
  input  logic                     ras_push,
  input  logic                     ras_pop,
  output logic [ADDRESS_WIDTH-1:0] PC,
  output logic [ADDRESS_WIDTH-1:0] PC_plus4,
  output logic                     misaligned,
  output logic [ADDRESS_WIDTH-1:0] ras_top,
  output logic                     ras_empty,
  output logic                     ras_full
);
  localparam logic [1:0] SRC_SEQ  = 2'b00;
  localparam logic [1:0] SRC_BR   = 2'b01;
  localparam logic [1:0] SRC_JR   = 2'b10;
  localparam logic [1:0] SRC_TRAP = 2'b11;

  logic [ADDRESS_WIDTH-1:0] target;
  logic [ADDRESS_WIDTH-1:0] next_pc;
  logic                     rel_mode;
  logic                     trap_mis;
  logic                     pop_eff;

  assign PC_plus4 = PC + ADDRESS_WIDTH'(4);
  assign rel_mode = (PCsrc == SRC_BR) || (PCsrc == SRC_JR);

  always_comb begin
    target = PC_plus4;
    case (PCsrc)
      SRC_SEQ:  target = PC_plus4;
      SRC_BR:   target = PC + ImmOP;
      SRC_JR:   target = (RegBase + ImmOP) & ~ADDRESS_WIDTH'(1);
      SRC_TRAP: target = TRAP_VECTOR;
      default:  target = PC_plus4;
    endcase
  end

  // A predicted return bypasses the computed target, so it is never checked for alignment.
  assign trap_mis = rel_mode && target[1] && !pop_eff;
  assign next_pc  = pop_eff  ? ras_top :
                    trap_mis ? TRAP_VECTOR : target;

  always_ff @(posedge clk) begin
    if (!rst) begin
      PC         <= RESET_VECTOR;
      misaligned <= 1'b0;
    end else if (en) begin
      PC         <= next_pc;
      misaligned <= trap_mis;
    end
  end

`ifdef PC_RAS_EN
  localparam int              PTR_W    = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(RAS_DEPTH);

  logic [ADDRESS_WIDTH-1:0] stack [RAS_DEPTH];
  logic [PTR_W-1:0]         sp;
  logic [PTR_W-1:0]         top_idx;
  logic [PTR_W:0]           count;
  logic                     push_eff;

  // sp names the next free slot; when full it also names the oldest entry, so a push overwrites it.
  assign top_idx   = sp - PTR_W'(1);
  assign ras_top   = stack[top_idx];
  assign ras_empty = (count == '0);
  assign ras_full  = (count == FULL_CNT);
  assign pop_eff   = en && (PCsrc == SRC_JR) && ras_pop && !ras_empty;
  assign push_eff  = en && rel_mode && ras_push && !trap_mis;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sp    <= '0;
      count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
    end else if (pop_eff && push_eff) begin
      stack[top_idx] <= PC_plus4;
    end else if (push_eff) begin
      stack[sp] <= PC_plus4;
      sp        <= sp + PTR_W'(1);
      if (!ras_full) count <= count + 1'b1;
    end else if (pop_eff) begin
      sp    <= top_idx;
      count <= count - 1'b1;
    end
  end
`else
  logic unused_ras;

  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
  assign pop_eff    = 1'b0;
  assign unused_ras = ras_push ^ ras_pop;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - vector table, hand sequences and randomized model check for pc_unit
module tb_pc_unit;
  localparam int          AW    = 32;
  localparam logic [31:0] RV    = 32'h0;
  localparam logic [31:0] TV    = 32'h100;
  localparam int          DEPTH = 4;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, en, ras_push, ras_pop;
  logic [1:0]    PCsrc;
  logic [AW-1:0] ImmOP, RegBase;
  logic [AW-1:0] PC, PC_plus4, ras_top;
  logic          misaligned, ras_empty, ras_full;

  pc_unit #(.ADDRESS_WIDTH(AW), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .PCsrc(PCsrc), .ImmOP(ImmOP), .RegBase(RegBase),
    .ras_push(ras_push), .ras_pop(ras_pop), .PC(PC), .PC_plus4(PC_plus4),
    .misaligned(misaligned), .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: PC, trap flag and the stack as a plain queue (back = top).
  logic [31:0] m_pc;
  bit          m_mis;
  logic [31:0] m_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc  = RV;
    m_mis = 1'b0;
    m_q.delete();
  endtask

  task automatic m_step(input bit e, input logic [1:0] s, input logic [31:0] imm,
                        input logic [31:0] base, input bit pu, input bit po);
    logic [31:0] tgt, link, nxt;
    bit          rel, pop_ok, push_ok, mis;
    if (!e) return;
    link = m_pc + 32'd4;
    case (s)
      2'd0:    tgt = link;
      2'd1:    tgt = m_pc + imm;
      2'd2:    tgt = (base + imm) & 32'hFFFF_FFFE;
      default: tgt = TV;
    endcase
    rel     = (s == 2'd1) || (s == 2'd2);
    pop_ok  = RAS_ON && (s == 2'd2) && po && (m_q.size() > 0);
    mis     = rel && tgt[1] && !pop_ok;
    push_ok = RAS_ON && rel && pu && !mis;
    nxt     = pop_ok ? m_q[$] : (mis ? TV : tgt);
    if (pop_ok && push_ok) m_q[$] = link;
    else if (pop_ok) void'(m_q.pop_back());
    else if (push_ok) begin
      if (m_q.size() == DEPTH) void'(m_q.pop_front());
      m_q.push_back(link);
    end
    m_pc  = nxt;
    m_mis = mis;
  endtask

  // Storage is cleared on reset, so an empty stack reads 0 until its first push.
  bit m_top_zero;

  task automatic check_all();
    chk("pc", PC, m_pc);
    chk("pc_plus4", PC_plus4, m_pc + 32'd4);
    chk("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
    chk("ras_empty", {31'd0, ras_empty}, {31'd0, m_q.size() == 0});
    chk("ras_full", {31'd0, ras_full}, {31'd0, m_q.size() == DEPTH});
    if (m_q.size() > 0) chk("ras_top", ras_top, m_q[$]);
    else if (m_top_zero) chk("ras_top_clr", ras_top, 32'd0);
  endtask

  task automatic cyc(input bit r, input bit e, input logic [1:0] s, input logic [31:0] imm,
                     input logic [31:0] base, input bit pu, input bit po);
    rst = r; en = e; PCsrc = s; ImmOP = imm; RegBase = base; ras_push = pu; ras_pop = po;
    @(posedge clk);
    if (!r) begin
      m_reset();
      m_top_zero = 1'b1;
    end else begin
      if (RAS_ON && e && pu && (s == 2'd1 || s == 2'd2)) m_top_zero = 1'b0;
      m_step(e, s, imm, base, pu, po);
    end
    #1;
    check_all();
  endtask

  typedef struct {
    bit          r;
    bit          e;
    logic [1:0]  s;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] pc;
    bit          mis;
  } vec_t;

  vec_t tbl[19];

  initial begin
    rst = 1'b0; en = 1'b0; PCsrc = 2'd0; ImmOP = '0; RegBase = '0; ras_push = 1'b0; ras_pop = 1'b0;
    m_reset();
    m_top_zero = 1'b1;

    tbl[0]  = '{0, 1, 2'd0, 32'h0,         32'h0,         32'h0,         0};
    tbl[1]  = '{1, 1, 2'd0, 32'h0,         32'h0,         32'h4,         0};
    tbl[2]  = '{1, 1, 2'd0, 32'h0,         32'h0,         32'h8,         0};
    tbl[3]  = '{1, 1, 2'd0, 32'h0,         32'h0,         32'hC,         0};
    tbl[4]  = '{1, 0, 2'd1, 32'h40,        32'h0,         32'hC,         0};
    tbl[5]  = '{1, 0, 2'd3, 32'h0,         32'h0,         32'hC,         0};
    tbl[6]  = '{1, 1, 2'd0, 32'h0,         32'h0,         32'h10,        0};
    tbl[7]  = '{1, 1, 2'd1, 32'hFFFF_FFF8, 32'h0,         32'h8,         0};
    tbl[8]  = '{1, 1, 2'd1, 32'h6,         32'h0,         TV,            1};
    tbl[9]  = '{1, 1, 2'd0, 32'h0,         32'h0,         32'h104,       0};
    tbl[10] = '{1, 1, 2'd2, 32'h0,         32'h203,       TV,            1};
    tbl[11] = '{1, 1, 2'd2, 32'h0,         32'h201,       32'h200,       0};
    tbl[12] = '{1, 1, 2'd1, 32'h2,         32'h0,         TV,            1};
    tbl[13] = '{1, 0, 2'd0, 32'h0,         32'h0,         TV,            1};
    tbl[14] = '{0, 0, 2'd0, 32'h0,         32'h0,         RV,            0};
    tbl[15] = '{1, 1, 2'd1, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC, 0};
    tbl[16] = '{1, 1, 2'd0, 32'h0,         32'h0,         32'h0,         0};
    tbl[17] = '{1, 1, 2'd3, 32'h0,         32'h0,         TV,            0};
    tbl[18] = '{1, 1, 2'd2, 32'h10,        32'hFFFF_FFF1, 32'h0,         0};

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].imm, tbl[i].base, 1'b0, 1'b0);
      chk($sformatf("vec%0d_pc", i), PC, tbl[i].pc);
      chk($sformatf("vec%0d_mis", i), {31'd0, misaligned}, {31'd0, tbl[i].mis});
    end

`ifdef PC_RAS_EN
    // call then return
    cyc(0, 1, 2'd0, 0, 0, 0, 0);
    cyc(1, 1, 2'd1, 32'h40, 0, 0, 0);
    cyc(1, 1, 2'd1, 32'h100, 0, 1, 0);
    chk("call_pc", PC, 32'h140);
    chk("call_top", ras_top, 32'h44);
    cyc(1, 1, 2'd2, 32'h0, 32'h0, 0, 1);
    chk("ret_pc", PC, 32'h44);
    chk("ret_empty", {31'd0, ras_empty}, 32'd1);
    // push on a misaligned trap and pushes in modes 00/11 are dropped
    cyc(1, 1, 2'd1, 32'h6, 0, 1, 0);
    cyc(1, 1, 2'd0, 0, 0, 1, 0);
    cyc(1, 1, 2'd3, 0, 0, 1, 1);
    chk("nopush_empty", {31'd0, ras_empty}, 32'd1);
    // overflow: five pushes, four pops, then pop on empty
    cyc(0, 1, 2'd0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 1, 2'd1, 32'h4, 0, 1, 0);
    chk("ovf_full", {31'd0, ras_full}, 32'd1);
    chk("ovf_top", ras_top, 32'h14);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 2'd2, 0, 32'h0, 0, 1);
      chk($sformatf("pop%0d_pc", k), PC, 32'h14 - 32'(k) * 32'h4);
    end
    chk("drain_empty", {31'd0, ras_empty}, 32'd1);
    cyc(1, 1, 2'd2, 0, 32'h300, 0, 1);
    chk("pop_empty_pc", PC, 32'h300);
    // simultaneous pop and push, then reset
    cyc(0, 1, 2'd0, 0, 0, 0, 0);
    cyc(1, 1, 2'd1, 32'h40, 0, 0, 0);
    cyc(1, 1, 2'd1, 32'h40, 0, 1, 0);
    chk("pp_setup_pc", PC, 32'h80);
    cyc(1, 1, 2'd2, 0, 32'h500, 1, 1);
    chk("pp_pc", PC, 32'h44);
    chk("pp_top", ras_top, 32'h84);
    chk("pp_empty", {31'd0, ras_empty}, 32'd0);
    cyc(0, 1, 2'd1, 32'h40, 0, 1, 0);
    chk("pp_rst_pc", PC, RV);
    chk("pp_rst_empty", {31'd0, ras_empty}, 32'd1);
    chk("pp_rst_top", ras_top, 32'd0);
`else
    // stack absent: push/pop have no effect and flags are constant
    cyc(0, 1, 2'd0, 0, 0, 0, 0);
    cyc(1, 1, 2'd1, 32'h40, 0, 1, 0);
    chk("nr_call_pc", PC, 32'h40);
    chk("nr_top", ras_top, 32'd0);
    cyc(1, 1, 2'd2, 32'h0, 32'h80, 1, 1);
    chk("nr_ret_pc", PC, 32'h80);
    chk("nr_empty", {31'd0, ras_empty}, 32'd1);
    chk("nr_full", {31'd0, ras_full}, 32'd0);
`endif

    // randomized run against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] imm;
      imm = $urandom & 32'h1FE;
      if ($urandom_range(0, 3) == 0) imm = -imm;
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 4) != 0, 2'($urandom_range(0, 3)),
          imm, $urandom & 32'hFFF, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit, successor to the single-mode PC register/adder/mux stage. Selects the next PC from four sources: sequential, PC-relative branch, register-indirect jump, trap vector. Holds on stall, traps on misaligned targets, and optionally predicts returns with a small return-address stack (RAS). Sits at the head of the fetch path and drives the instruction-memory address.

## Interface
- `ADDRESS_WIDTH`, 32: width of PC, immediates and targets.
- `RESET_VECTOR`, 0: PC value after reset.
- `TRAP_VECTOR`, 32'h0000_0100: PC loaded on trap or misaligned target.
- `RAS_DEPTH`, 4: return-address stack entries, power of two, ≥2.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `en`  in  1  advance enable; 0 = stall, all state held.
- `PCsrc`  in  2  00 PC+4, 01 PC+ImmOP, 10 (RegBase+ImmOP)&~1, 11 TRAP_VECTOR.
- `ImmOP`  in  ADDRESS_WIDTH  sign-extended immediate.
- `RegBase`  in  ADDRESS_WIDTH  rs1 value for indirect jumps.
- `ras_push`  in  1  push PC+4 (call).
- `ras_pop`  in  1  use and pop stack top (return).
- `PC`  out  ADDRESS_WIDTH  current PC, registered.
- `PC_plus4`  out  ADDRESS_WIDTH  PC+4, combinational (link value).
- `misaligned`  out  1  registered; 1 for the cycle after a misaligned-target trap.
- `ras_top`  out  ADDRESS_WIDTH  current stack top, combinational.
- `ras_empty`, `ras_full`  out  1 each  stack occupancy flags.

## Operation
- Target: 00 → PC+4; 01 → PC+ImmOP; 10 → (RegBase+ImmOP) with bit 0 cleared; 11 → TRAP_VECTOR. All sums modulo 2^ADDRESS_WIDTH, carry discarded; wrap from all-ones is legal.
- Misaligned check applies to modes 01/10 only: target bit 1 set → next PC = TRAP_VECTOR, `misaligned` ← 1. Otherwise `misaligned` ← 0 on every enabled cycle.
- RAS pop: effective only when `en`=1, `PCsrc`=10, `ras_pop`=1, stack non-empty. Next PC = `ras_top` (not the computed target, no misaligned check), count decrements. Pop on empty: ignored, computed target used.
- RAS push: effective when `en`=1, `ras_push`=1, `PCsrc` ∈ {01,10}. Writes PC+4. Push on full overwrites the oldest entry (circular pointer), count stays RAS_DEPTH.
- Simultaneous effective pop and push: top replaced by PC+4, count unchanged; next PC = old top.
- Misaligned trap on a push cycle: push suppressed.
- `PCsrc`=11 or 00: `ras_push`/`ras_pop` ignored.

## Timing
- Reset (`rst`=0 at edge, priority over `en`): PC=RESET_VECTOR, `misaligned`=0, stack pointer and count 0 → `ras_empty`=1, `ras_full`=0, `ras_top`=0 (entry storage also cleared). Reset mid-stall or mid-trap is identical.
- Latency: next PC visible on `PC` one cycle after the enabled edge; `PC_plus4`/`ras_top` follow combinationally.
- `en`=0: PC, stack, `misaligned` all hold; inputs ignored.
- Flags derived from the registered count; valid the same cycle as `PC`.

## Configuration
- `PC_RAS_EN` defined: RAS built as above with RAS_DEPTH entries.
- Undefined: no stack storage; `ras_push`/`ras_pop` ignored; `ras_top`=0, `ras_empty`=1, `ras_full`=0 constant; mode 10 always uses computed target.

## Test plan
- Reset with RESET_VECTOR=0, then 3 enabled cycles `PCsrc`=00 → PC 0,4,8,12; drop `en` 2 cycles → PC held at 12.
- PC=0x10, `PCsrc`=01, ImmOP=0xFFFF_FFF8 → PC=0x08; ImmOP=0x6 → PC=TRAP_VECTOR, `misaligned`=1 one cycle, then 0.
- RegBase=0x203, ImmOP=0, `PCsrc`=10 → PC=0x202 → misaligned trap; RegBase=0x201 → PC=0x200, no trap.
- `PC_RAS_EN`, PC=0x40, call (`PCsrc`=01, ImmOP=0x100, push) → PC=0x140, `ras_top`=0x44; return (`PCsrc`=10, pop) → PC=0x44, `ras_empty`=1.
- `PC_RAS_EN`, RAS_DEPTH=4: 5 pushes of 0x4,0x8,0xC,0x10,0x14 → `ras_full`=1, 4 pops yield 0x14,0x10,0xC,0x8 then `ras_empty`=1; further pop uses computed target.
- Pop+push same cycle with top 0x44, PC=0x80 → PC=0x44, `ras_top`=0x84, count unchanged; `rst`=0 asserted next → PC=RESET_VECTOR, `ras_empty`=1.
